// File: rtl/imem_loader.sv
// Boot loader: packs a length-prefixed little-endian byte stream into 32-bit words
// and writes them to instruction memory while holding the core in reset.
module imem_loader #(
    parameter int          MAX_WORDS = 64,
    parameter logic [63:0] BASE_ADDR = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        restart,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    output logic        imem_we,
    output logic [63:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_hold,
    output logic        done,
    output logic        overflow
);

    typedef enum logic [1:0] {LEN_LO, LEN_HI, DATA, DONE} state_t;

    localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

    state_t      state_reg, state_next;
    logic [15:0] n_reg;
    logic [1:0]  byte_cnt_reg;
    logic [15:0] word_idx_reg;
    logic [23:0] asm_reg;     // first three bytes of the word being assembled
    logic        xfer;
    logic        word_done;
    logic        last_word;
    logic [31:0] word;

    assign in_ready  = (state_reg != DONE) & reset;
    assign xfer      = in_valid & in_ready;
    assign word_done = xfer & (state_reg == DATA) & (byte_cnt_reg == 2'd3);
    assign last_word = (word_idx_reg + 16'd1) == n_reg;
    assign word      = {in_byte, asm_reg};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= LEN_LO;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            LEN_LO: if (xfer) state_next = LEN_HI;
            LEN_HI: if (xfer) state_next = ({in_byte, n_reg[7:0]} == 16'd0) ? DONE : DATA;
            DATA:   if (word_done && last_word) state_next = DONE;
            DONE:   if (restart) state_next = LEN_LO;
            default: state_next = LEN_LO;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_reg        <= 16'd0;
            byte_cnt_reg <= 2'd0;
            word_idx_reg <= 16'd0;
            asm_reg      <= 24'd0;
            imem_we      <= 1'b0;
            imem_addr    <= BASE_ADDR;
            imem_wdata   <= 32'd0;
            core_hold    <= 1'b1;
            done         <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state_reg)
                LEN_LO: begin
                    if (xfer) n_reg[7:0] <= in_byte;
                end
                LEN_HI: begin
                    if (xfer) begin
                        n_reg[15:8]  <= in_byte;
                        byte_cnt_reg <= 2'd0;
                        word_idx_reg <= 16'd0;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        asm_reg      <= {in_byte, asm_reg[23:8]};
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        if (byte_cnt_reg == 2'd3) begin
                            imem_wdata   <= word;
                            imem_addr    <= BASE_ADDR + {46'd0, word_idx_reg, 2'b00};
                            // Words past capacity are consumed but never written.
                            if ({16'd0, word_idx_reg} < MAX_W) begin
                                imem_we <= 1'b1;
                            end else begin
                                overflow <= 1'b1;
                            end
                            word_idx_reg <= word_idx_reg + 16'd1;
                        end
                    end
                end
                DONE: begin
                    if (restart) begin
                        done         <= 1'b0;
                        overflow     <= 1'b0;
                        word_idx_reg <= 16'd0;
                        core_hold    <= 1'b1;
                    end else begin
                        // One edge after entering DONE, so the last write is already sampled.
                        done      <= 1'b1;
                        core_hold <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven loads plus hand-written
// sequences for exact timing, async reset and restart; writes go through a scoreboard.
module tb_imem_loader;

    localparam int          MAXW = 2;
    localparam logic [63:0] BASE = 64'h0000_0001_0000_0000;

    logic        clk;
    logic        reset;
    logic        restart;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        imem_we;
    logic [63:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_hold;
    logic        done;
    logic        overflow;

    imem_loader #(.MAX_WORDS(MAXW), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .reset      (reset),
        .restart    (restart),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .done       (done),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [15:0]      n;
        int               nw;
        logic [2:0][31:0] w;
        bit               rnd;
        bit               noise;
        bit               ovf;
    } case_t;

    wr_t   sb[$];
    case_t tbl[5];
    int    checks = 0;
    int    passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Advance one clock and retire any memory write against the scoreboard.
    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        if (imem_we === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_we", 64'(imem_we), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", imem_addr, e.addr);
                chk("wr_data", 64'(imem_wdata), 64'(e.data));
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd, input bit noise);
        if (rnd) begin
            while ($urandom_range(1, 0) == 0) begin
                in_valid = 1'b0;
                in_byte  = 8'($urandom);
                restart  = noise ? 1'($urandom_range(1, 0)) : 1'b0;
                tick();
            end
        end
        in_valid = 1'b1;
        in_byte  = b;
        restart  = noise ? 1'($urandom_range(1, 0)) : 1'b0;
        chk("in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        restart  = 1'b0;
    endtask

    task automatic send_stream(input logic [15:0] n, input int nw, input logic [2:0][31:0] w,
                               input bit rnd, input bit noise);
        bit last;
        send_byte(n[7:0], rnd, noise);
        send_byte(n[15:8], rnd, noise && (nw != 0));
        for (int i = 0; i < nw; i++) begin
            for (int k = 0; k < 4; k++) begin
                last = (i == nw - 1) && (k == 3);
                if (k == 3 && i < MAXW) sb.push_back('{addr: BASE + 64'(4 * i), data: w[i]});
                send_byte(w[i][8*k +: 8], rnd, noise && !last);
            end
        end
    endtask

    task automatic do_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("restart_hold", 64'(core_hold), 64'd1);
        chk("restart_done", 64'(done), 64'd0);
        chk("restart_ovf", 64'(overflow), 64'd0);
        chk("restart_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0][31:0] w;

        tbl[0] = '{n: 16'd2, nw: 2, w: {32'h0, 32'h00A00093, 32'h00500013}, rnd: 1, noise: 0, ovf: 0};
        tbl[1] = '{n: 16'd3, nw: 3, w: {32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D}, rnd: 0, noise: 0, ovf: 1};
        tbl[2] = '{n: 16'd1, nw: 1, w: {32'h0, 32'h0, 32'h12345678}, rnd: 1, noise: 1, ovf: 0};
        tbl[3] = '{n: 16'd0, nw: 0, w: {32'h0, 32'h0, 32'h0}, rnd: 0, noise: 0, ovf: 0};
        tbl[4] = '{n: 16'd2, nw: 2, w: {32'h0, 32'hFEEDFACE, 32'h0BADC0DE}, rnd: 1, noise: 1, ovf: 0};

        reset    = 1'b0;
        restart  = 1'b0;
        in_valid = 1'b0;
        in_byte  = 8'd0;
        tick();
        tick();
        chk("rst_we", 64'(imem_we), 64'd0);
        chk("rst_addr", imem_addr, BASE);
        chk("rst_wdata", 64'(imem_wdata), 64'd0);
        chk("rst_hold", 64'(core_hold), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("post_rst_ready", 64'(in_ready), 64'd1);

        // Back-to-back stream with exact done/core_hold timing.
        w = {32'h0, 32'h00A00093, 32'h00500013};
        send_stream(16'd2, 2, w, 1'b0, 1'b0);
        chk("s1_done_early", 64'(done), 64'd0);
        chk("s1_hold_early", 64'(core_hold), 64'd1);
        chk("s1_ready_done", 64'(in_ready), 64'd0);
        tick();
        chk("s1_done", 64'(done), 64'd1);
        chk("s1_hold", 64'(core_hold), 64'd0);
        chk("s1_sb_empty", 64'(sb.size()), 64'd0);

        for (int c = 0; c < 5; c++) begin
            do_restart();
            send_stream(tbl[c].n, tbl[c].nw, tbl[c].w, tbl[c].rnd, tbl[c].noise);
            chk($sformatf("t%0d_done_early", c), 64'(done), 64'd0);
            chk($sformatf("t%0d_ovf", c), 64'(overflow), 64'(tbl[c].ovf));
            tick();
            chk($sformatf("t%0d_done", c), 64'(done), 64'd1);
            chk($sformatf("t%0d_hold", c), 64'(core_hold), 64'd0);
            chk($sformatf("t%0d_ready", c), 64'(in_ready), 64'd0);
            tick();
            chk($sformatf("t%0d_ovf_sticky", c), 64'(overflow), 64'(tbl[c].ovf));
            chk($sformatf("t%0d_sb_empty", c), 64'(sb.size()), 64'd0);
        end

        // Asynchronous reset after six data bytes.
        do_restart();
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        sb.push_back('{addr: BASE, data: 32'h00500013});
        send_byte(8'h13, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h50, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h93, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_we", 64'(imem_we), 64'd0);
        chk("arst_addr", imem_addr, BASE);
        chk("arst_wdata", 64'(imem_wdata), 64'd0);
        chk("arst_hold", 64'(core_hold), 64'd1);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_ready", 64'(in_ready), 64'd0);
        tick();
        tick();
        @(negedge clk);
        reset = 1'b1;
        tick();
        w = {32'h0, 32'h00100093, 32'h00000013};
        send_stream(16'd2, 2, w, 1'b0, 1'b0);
        tick();
        chk("arst_reload_done", 64'(done), 64'd1);
        chk("arst_sb_empty", 64'(sb.size()), 64'd0);

        // Restart and load a single word.
        do_restart();
        w = {32'h0, 32'h0, 32'hDEADBEEF};
        send_stream(16'd1, 1, w, 1'b0, 1'b0);
        chk("rs_done_early", 64'(done), 64'd0);
        tick();
        chk("rs_done", 64'(done), 64'd1);
        chk("rs_hold", 64'(core_hold), 64'd0);
        chk("rs_sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that sits directly upstream of the single-cycle RISC-V core and its instruction memory. It accepts a length-prefixed little-endian byte stream over a valid/ready handshake and packs it into 32-bit instruction words. It writes each word into the instruction memory write port at consecutive word addresses, holding the core in reset until the whole image is written. After the load completes it releases the core and ignores further input until restarted.

## Interface
- `MAX_WORDS`, 64: instruction memory capacity in 32-bit words; words beyond this are consumed but not written.
- `BASE_ADDR`, 64'd0: byte address of the first written word.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset: 0 resets immediately, release is synchronous to `clk` usage.
- `restart`  in  1  synchronous pulse; in DONE, starts a new load.
- `in_valid`  in  1  byte on `in_byte` is valid.
- `in_byte`  in  8  stream byte.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `imem_we`  out  1  one-cycle instruction memory write strobe.
- `imem_addr`  out  64  byte address of the write, word-aligned.
- `imem_wdata`  out  32  instruction word to write.
- `core_hold`  out  1  active-high reset/hold for the core; 1 while loading.
- `done`  out  1  load complete, level.
- `overflow`  out  1  sticky: stream declared more than `MAX_WORDS` words.

## Operation
- A transfer occurs on any rising edge where `in_valid & in_ready`. `in_ready` = (state != DONE) & `reset`; it is combinational from state only, with no dependency on `in_valid`.
- Stream format: byte 0 = N[7:0], byte 1 = N[15:8], then 4·N data bytes. Each word is little-endian: the first byte goes to [7:0] and the fourth byte to [31:24].
- States:
  - LEN_LO: capture N[7:0], go to LEN_HI.
  - LEN_HI: capture N[15:8]. If N==0, go to DONE. Otherwise go to DATA with byte_cnt=0 and word_idx=0.
  - DATA: shift each byte into a 32-bit assembly register and increment byte_cnt (2 bits, wraps 3->0). When the 4th byte is accepted:
    - register `imem_wdata` = assembled word.
    - register `imem_addr` = BASE_ADDR + 4·word_idx.
    - set `imem_we`=1 for the next cycle only if word_idx < MAX_WORDS; otherwise set `overflow`.
    - increment word_idx (16-bit, compared against N).
    - if word_idx+1 == N, go to DONE.
  - DONE: `in_ready`=0. `restart`=1 returns to LEN_LO, clears `done`, `overflow` and word_idx, and sets `core_hold`=1.
- `imem_addr` arithmetic is 64-bit. word_idx is zero-extended and shifted left by 2. No address wraps, because writes stop at MAX_WORDS.
- `restart` outside DONE is ignored.
- `in_valid` deasserted mid-word: the partial word and byte_cnt are held indefinitely.

## Timing
- Reset values (on `reset`=0, asynchronous):
  - state=LEN_LO, byte_cnt=0, word_idx=0, N=0.
  - `imem_we`=0, `imem_addr`=BASE_ADDR, `imem_wdata`=0.
  - `core_hold`=1, `done`=0, `overflow`=0, `in_ready`=0.
- Reset asserted mid-load discards all progress. Memory contents already written are not cleared.
- Write latency: 4th byte accepted at edge t, so `imem_we`/`imem_addr`/`imem_wdata` are valid during cycle t..t+1 and sampled by memory at edge t+1.
- The last byte accepted at edge t puts the state in DONE after t. `done`=1 and `core_hold`=0 after edge t+1, so the core leaves reset only after the last write has been sampled.
- N==0: `done`=1 and `core_hold`=0 one edge after LEN_HI is accepted.
- Throughput: one byte per cycle sustained, so back-to-back words give a `imem_we` pulse every 4 cycles.
- `restart` in DONE: `core_hold`=1 and `done`=0 after the same edge, and `in_ready`=1 in the following cycle.

## Test plan
- Reset then stream 02 00 13 00 50 00 93 00 A0 00, valid every cycle:
  - writes 0x00500013 @0 and 0x00A00093 @4, each `imem_we` exactly one cycle.
  - `done`=1 and `core_hold`=0 one edge after the second write.
- Same stream with `in_valid` toggled randomly (50%): identical writes and addresses, with no extra or missing `imem_we`.
- N=0 (00 00): no `imem_we`. `done` rises one edge after byte 1, and `in_ready`=0 thereafter.
- MAX_WORDS=2, N=3, 12 data bytes:
  - exactly 2 writes (@0, @4).
  - `overflow`=1 after the 3rd word's 4th byte, and `done`=1.
- Assert `reset`=0 asynchronously after 6 data bytes:
  - outputs go to reset values immediately, without waiting for a clock edge.
  - a fresh full stream then loads correctly from address BASE_ADDR.
- After `done`, pulse `restart` and send 01 00 EF BE AD DE:
  - `core_hold` reasserts and `done` clears.
  - one write of 0xDEADBEEF @BASE_ADDR, then `done`=1.
